// File: rtl/nibble_serial_adder.sv
// Multi-cycle W-bit adder that reuses one 4-bit add slice, one nibble per clock,
// least-significant nibble first, rippling the carry through a register.
module nibble_serial_adder #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [4*NIBBLES-1:0]   a,
    input  logic [4*NIBBLES-1:0]   b,
    input  logic                   cin,
    output logic                   busy,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   sum,
    output logic                   cout
);
    localparam int W     = 4 * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // The shared 4-bit slice: returns {cout, sum} for (a, b, cin).
    function automatic logic [4:0] slice_add4(input logic [3:0] sa,
                                              input logic [3:0] sb,
                                              input logic       scin);
        return {1'b0, sa} + {1'b0, sb} + {4'b0000, scin};
    endfunction

    state_t             r_state;
    state_t             w_next;
    logic [W-1:0]       r_a;
    logic [W-1:0]       r_b;
    logic               r_carry;
    logic [IDX_W-1:0]   r_idx;
    logic [W-1:0]       r_sum;
    logic               r_cout;

    logic [IDX_W+1:0]   w_base;
    logic [3:0]         w_a_nib;
    logic [3:0]         w_b_nib;
    logic [4:0]         w_slice;
    logic               w_last;

    assign w_base  = {r_idx, 2'b00};
    assign w_a_nib = r_a[w_base +: 4];
    assign w_b_nib = r_b[w_base +: 4];
    assign w_slice = slice_add4(w_a_nib, w_b_nib, r_carry);
    assign w_last  = (r_idx == LAST_IDX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_RUN;
            S_RUN:   if (w_last) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_idx   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_carry <= cin;
                        r_idx   <= '0;
                        r_sum   <= '0;
                    end
                end
                S_RUN: begin
                    r_sum[w_base +: 4] <= w_slice[3:0];
                    r_carry            <= w_slice[4];
                    // Index parks on the last nibble rather than wrapping.
                    if (w_last) r_cout <= w_slice[4];
                    else        r_idx  <= r_idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy = (r_state == S_RUN);
    assign done = (r_state == S_DONE);
    assign sum  = r_sum;
    assign cout = r_cout;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Randomized and directed checks of nibble_serial_adder against a plain
// arithmetic reference ({cout,sum} = a + b + cin).
module tb_nibble_serial_adder;
    localparam int NIBBLES = 4;
    localparam int W = 4 * NIBBLES;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    int total = 0;
    int bad = 0;

    nibble_serial_adder #(.NIBBLES(NIBBLES)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    endfunction

    // One complete addition; optionally pulses start with junk operands mid-run.
    task automatic run_add(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tcin,
                           input bit poke_start);
        logic [W:0] exp;
        int c, busy_n, extra_done;
        bit got;
        exp = ref_add(ta, tb_v, tcin);
        @(negedge clk);
        start = 1'b1; a = ta; b = tb_v; cin = tcin;
        @(posedge clk);
        c = 0; busy_n = 0; got = 0;
        while (!got && c < 20) begin
            @(negedge clk);
            c++;
            if (c == 1) begin
                start = 1'b0; a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
            end
            if (poke_start && c == 2) begin start = 1'b1; a = 16'h1111; end
            if (poke_start && c == 3) start = 1'b0;
            check_eq("busy_done_overlap", {31'd0, busy & done}, 32'd0);
            if (busy) busy_n++;
            if (done) got = 1;
        end
        check_eq("done_latency", c, NIBBLES + 1);
        check_eq("busy_cycles", busy_n, NIBBLES);
        check_eq("sum", {16'd0, sum}, {16'd0, exp[W-1:0]});
        check_eq("cout", {31'd0, cout}, {31'd0, exp[W]});
        extra_done = 0;
        for (int i = 0; i < NIBBLES + 3; i++) begin
            @(negedge clk);
            if (done) extra_done++;
        end
        check_eq("no_extra_done", extra_done, 0);
        check_eq("sum_stable", {16'd0, sum}, {16'd0, exp[W-1:0]});
    endtask

    initial begin
        logic [W:0] e1, e2;
        int d, seen;

        // Asynchronous reset mid-cycle, before any clock edge.
        #2 rst = 1'b1;
        #1;
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_done", {31'd0, done}, 32'd0);
        check_eq("rst_sum", {16'd0, sum}, 32'd0);
        check_eq("rst_cout", {31'd0, cout}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        run_add(16'h0002, 16'h0006, 1'b0, 0);
        run_add(16'hFFFF, 16'h0001, 1'b0, 0);
        run_add(16'hFFFF, 16'hFFFF, 1'b1, 0);
        run_add(16'h0E06, 16'h0004, 1'b1, 1);

        // Reset after two RUN edges discards the partial result.
        @(negedge clk);
        start = 1'b1; a = 16'h1234; b = 16'h4321; cin = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check_eq("midrun_rst_busy", {31'd0, busy}, 32'd0);
        check_eq("midrun_rst_sum", {16'd0, sum}, 32'd0);
        check_eq("midrun_rst_cout", {31'd0, cout}, 32'd0);
        seen = 0;
        for (int i = 0; i < NIBBLES + 2; i++) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        check_eq("midrun_rst_quiet", seen, 0);
        run_add(16'h1234, 16'h4321, 1'b0, 0);

        // Back-to-back with start held high through DONE.
        e1 = ref_add(16'h8000, 16'h8000, 1'b0);
        e2 = ref_add(16'h0001, 16'h0001, 1'b0);
        @(negedge clk);
        start = 1'b1; a = 16'h8000; b = 16'h8000; cin = 1'b0;
        @(posedge clk);
        @(negedge clk);
        a = 16'h0001; b = 16'h0001;
        d = 0;
        while (!done && d < 20) begin @(negedge clk); d++; end
        check_eq("b2b_first_seen", {31'd0, done}, 32'd1);
        check_eq("b2b_first_sum", {16'd0, sum}, {16'd0, e1[W-1:0]});
        check_eq("b2b_first_cout", {31'd0, cout}, {31'd0, e1[W]});
        d = 0;
        @(negedge clk); d++;
        @(negedge clk); d++;
        check_eq("b2b_second_accept", {31'd0, busy}, 32'd1);
        start = 1'b0;
        while (!done && d < 20) begin @(negedge clk); d++; end
        check_eq("b2b_interval", d, NIBBLES + 2);
        check_eq("b2b_second_sum", {16'd0, sum}, {16'd0, e2[W-1:0]});
        check_eq("b2b_second_cout", {31'd0, cout}, {31'd0, e2[W]});

        // Randomized operands.
        for (int n = 0; n < 25; n++) begin
            run_add(W'($urandom), W'($urandom), 1'($urandom), bit'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
